// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use bubbles, taken-branch flushes, memory-wait freeze and timeout.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_sequencer #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       DE_rs1,
    input  logic [4:0]       DE_rs2,
    input  logic             DE_uses_rs1,
    input  logic             DE_uses_rs2,
    input  logic [4:0]       DE_EX_rd,
    input  logic             DE_EX_memRead,
    input  logic             EX_branch_taken,
    input  logic             MEM_req,
    input  logic             MEM_ready,
    output logic             PC_write,
    output logic             IF_DE_write,
    output logic             IF_DE_flush,
    output logic             DE_EX_write,
    output logic             DE_EX_flush,
    output logic             EX_MEM_write,
    output logic             MEM_WB_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] TIMEOUT  = 2'd2;

    logic [1:0]        state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_nx;
    logic              err_nx;
    logic              frozen;
    logic              hazard;
    logic              branch_apply;
    logic              load_use_apply;

    assign hazard = DE_EX_memRead && (DE_EX_rd != 5'd0) &&
                    ((DE_uses_rs1 && (DE_rs1 == DE_EX_rd)) ||
                     (DE_uses_rs2 && (DE_rs2 == DE_EX_rd)));

    // Freeze covers the detecting RUN cycle, every unfinished wait cycle and TIMEOUT.
    always_comb begin
        frozen = 1'b0;
        case (state)
            RUN:      frozen = MEM_req && !MEM_ready;
            MEM_WAIT: frozen = !MEM_ready;
            TIMEOUT:  frozen = 1'b1;
            default:  frozen = 1'b0;
        endcase
    end

    assign branch_apply   = !frozen && EX_branch_taken;
    assign load_use_apply = !frozen && !EX_branch_taken && hazard;

    // Pipeline control: reset > freeze > branch flush > load-use stall.
    always_comb begin
        PC_write      = 1'b1;
        IF_DE_write   = 1'b1;
        IF_DE_flush   = 1'b0;
        DE_EX_write   = 1'b1;
        DE_EX_flush   = 1'b0;
        EX_MEM_write  = 1'b1;
        MEM_WB_bubble = 1'b0;
        if (RST) begin
            PC_write      = 1'b0;
            IF_DE_write   = 1'b0;
            IF_DE_flush   = 1'b1;
            DE_EX_flush   = 1'b1;
            EX_MEM_write  = 1'b0;
            MEM_WB_bubble = 1'b1;
        end else if (frozen) begin
            PC_write      = 1'b0;
            IF_DE_write   = 1'b0;
            DE_EX_write   = 1'b0;
            EX_MEM_write  = 1'b0;
            MEM_WB_bubble = 1'b1;
        end else if (branch_apply) begin
            IF_DE_flush   = 1'b1;
            DE_EX_flush   = 1'b1;
        end else if (load_use_apply) begin
            PC_write      = 1'b0;
            IF_DE_write   = 1'b0;
            DE_EX_flush   = 1'b1;
        end
    end

    // wait_cnt holds the number of wait cycles already spent when in MEM_WAIT.
    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        err_nx   = mem_err;
        case (state)
            RUN: begin
                if (MEM_req && !MEM_ready) begin
                    state_nx = MEM_WAIT;
                    wait_nx  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (MEM_ready) begin
                    state_nx = RUN;
                    wait_nx  = '0;
                end else if ((MAX_WAIT != 0) && (wait_cnt == WAIT_W'(MAX_WAIT))) begin
                    state_nx = TIMEOUT;
                    err_nx   = 1'b1;
                end else begin
                    wait_nx  = wait_cnt + WAIT_W'(1);
                end
            end
            TIMEOUT:  state_nx = TIMEOUT;
            default:  state_nx = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            mem_err  <= err_nx;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Saturating event counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((frozen || load_use_apply) && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if (branch_apply && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer with a short memory timeout (MAX_WAIT=4).
module tb_hazard_sequencer;

    localparam int unsigned CNT_W = 32;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {PC_write, IF_DE_write, IF_DE_flush, DE_EX_write, DE_EX_flush, EX_MEM_write, MEM_WB_bubble}
    localparam logic [6:0] RUNV    = 7'b1101010;
    localparam logic [6:0] FREEZE  = 7'b0000001;
    localparam logic [6:0] LOADUSE = 7'b0001110;
    localparam logic [6:0] BRANCH  = 7'b1111110;
    localparam logic [6:0] RST_MSK = 7'b1110111;
    localparam logic [6:0] RSTV    = 7'b0010101;

    logic             CLK = 1'b0;
    logic             RST;
    logic [4:0]       DE_rs1, DE_rs2, DE_EX_rd;
    logic             DE_uses_rs1, DE_uses_rs2, DE_EX_memRead;
    logic             EX_branch_taken, MEM_req, MEM_ready;
    logic             PC_write, IF_DE_write, IF_DE_flush, DE_EX_write;
    logic             DE_EX_flush, EX_MEM_write, MEM_WB_bubble, mem_err;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [6:0]       ctl;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    hazard_sequencer #(.MAX_WAIT(4), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .DE_rs1(DE_rs1), .DE_rs2(DE_rs2),
        .DE_uses_rs1(DE_uses_rs1), .DE_uses_rs2(DE_uses_rs2),
        .DE_EX_rd(DE_EX_rd), .DE_EX_memRead(DE_EX_memRead),
        .EX_branch_taken(EX_branch_taken),
        .MEM_req(MEM_req), .MEM_ready(MEM_ready),
        .PC_write(PC_write), .IF_DE_write(IF_DE_write), .IF_DE_flush(IF_DE_flush),
        .DE_EX_write(DE_EX_write), .DE_EX_flush(DE_EX_flush),
        .EX_MEM_write(EX_MEM_write), .MEM_WB_bubble(MEM_WB_bubble),
        .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    assign ctl = {PC_write, IF_DE_write, IF_DE_flush, DE_EX_write,
                  DE_EX_flush, EX_MEM_write, MEM_WB_bubble};

    always #5 CLK = ~CLK;

    task automatic idle_inputs;
        DE_rs1 = 5'd0; DE_rs2 = 5'd0; DE_EX_rd = 5'd0;
        DE_uses_rs1 = 1'b0; DE_uses_rs2 = 1'b0; DE_EX_memRead = 1'b0;
        EX_branch_taken = 1'b0; MEM_req = 1'b0; MEM_ready = 1'b0;
    endtask

    task automatic test_counters(input string tag);
        logic [CNT_W-1:0] es, ef;
        es = PERF ? CNT_W'(exp_stall) : '0;
        ef = PERF ? CNT_W'(exp_flush) : '0;
        checks++;
        if (stall_cycles !== es) begin
            errors++;
            $display("FAIL %s stall_cycles got %0d expected %0d", tag, stall_cycles, es);
        end
        checks++;
        if (flush_count !== ef) begin
            errors++;
            $display("FAIL %s flush_count got %0d expected %0d", tag, flush_count, ef);
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        idle_inputs();
        EX_branch_taken = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        checks++;
        if ((ctl & RST_MSK) !== RSTV) begin
            errors++;
            $display("FAIL reset_ctl got %b expected %b (masked)", ctl & RST_MSK, RSTV);
        end
        checks++;
        if (mem_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem_err got %b expected 0", mem_err);
        end
        exp_stall = 0; exp_flush = 0;
        test_counters("reset");
        @(negedge CLK);
        RST = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if (ctl !== RUNV) begin
            errors++;
            $display("FAIL default_run got %b expected %b", ctl, RUNV);
        end
        @(negedge CLK);
    endtask

    task automatic test_load_use;
        // ld x5 in EX, add x6,x5,x1 in DE
        DE_EX_memRead = 1'b1; DE_EX_rd = 5'd5;
        DE_rs1 = 5'd5; DE_uses_rs1 = 1'b1; DE_rs2 = 5'd1; DE_uses_rs2 = 1'b1;
        #1;
        checks++;
        if (ctl !== LOADUSE) begin
            errors++;
            $display("FAIL load_use_rs1 got %b expected %b", ctl, LOADUSE);
        end
        exp_stall++;
        @(negedge CLK);
        DE_EX_memRead = 1'b0; DE_EX_rd = 5'd6;
        #1;
        checks++;
        if (ctl !== RUNV) begin
            errors++;
            $display("FAIL load_use_release got %b expected %b", ctl, RUNV);
        end
        @(negedge CLK);
        DE_EX_memRead = 1'b1; DE_EX_rd = 5'd7;
        DE_rs1 = 5'd2; DE_uses_rs1 = 1'b1; DE_rs2 = 5'd7; DE_uses_rs2 = 1'b1;
        #1;
        checks++;
        if (ctl !== LOADUSE) begin
            errors++;
            $display("FAIL load_use_rs2 got %b expected %b", ctl, LOADUSE);
        end
        exp_stall++;
        @(negedge CLK);
        DE_uses_rs2 = 1'b0;
        #1;
        checks++;
        if (ctl !== RUNV) begin
            errors++;
            $display("FAIL rs2_not_used got %b expected %b", ctl, RUNV);
        end
        @(negedge CLK);
        idle_inputs();
    endtask

    task automatic test_no_stall;
        DE_EX_memRead = 1'b1; DE_EX_rd = 5'd0; DE_rs1 = 5'd0; DE_uses_rs1 = 1'b1;
        #1;
        checks++;
        if (ctl !== RUNV) begin
            errors++;
            $display("FAIL load_x0 got %b expected %b", ctl, RUNV);
        end
        @(negedge CLK);
        DE_EX_memRead = 1'b0; DE_EX_rd = 5'd5; DE_rs1 = 5'd5;
        #1;
        checks++;
        if (ctl !== RUNV) begin
            errors++;
            $display("FAIL non_load_match got %b expected %b", ctl, RUNV);
        end
        @(negedge CLK);
        idle_inputs();
        #1;
        test_counters("after_load_use");
    endtask

    task automatic test_branch_priority;
        DE_EX_memRead = 1'b1; DE_EX_rd = 5'd5; DE_rs1 = 5'd5; DE_uses_rs1 = 1'b1;
        EX_branch_taken = 1'b1;
        #1;
        checks++;
        if (ctl !== BRANCH) begin
            errors++;
            $display("FAIL branch_over_load_use got %b expected %b", ctl, BRANCH);
        end
        exp_flush++;
        @(negedge CLK);
        idle_inputs();
        #1;
        test_counters("branch");
    endtask

    task automatic test_mem_wait;
        MEM_req = 1'b1; MEM_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== FREEZE) begin
                errors++;
                $display("FAIL mem_wait_freeze[%0d] got %b expected %b", i, ctl, FREEZE);
            end
            exp_stall++;
            @(negedge CLK);
        end
        MEM_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== RUNV) begin
            errors++;
            $display("FAIL mem_wait_release got %b expected %b", ctl, RUNV);
        end
        @(negedge CLK);
        #1;
        checks++;
        if (ctl !== RUNV) begin
            errors++;
            $display("FAIL mem_ready_same_cycle got %b expected %b", ctl, RUNV);
        end
        @(negedge CLK);
        idle_inputs();
        #1;
        test_counters("mem_wait");
    endtask

    task automatic test_branch_during_wait;
        MEM_req = 1'b1; MEM_ready = 1'b0; EX_branch_taken = 1'b1;
        DE_EX_memRead = 1'b1; DE_EX_rd = 5'd9; DE_rs2 = 5'd9; DE_uses_rs2 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (ctl !== FREEZE) begin
                errors++;
                $display("FAIL branch_frozen[%0d] got %b expected %b", i, ctl, FREEZE);
            end
            exp_stall++;
            @(negedge CLK);
        end
        MEM_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== BRANCH) begin
            errors++;
            $display("FAIL branch_on_release got %b expected %b", ctl, BRANCH);
        end
        exp_flush++;
        @(negedge CLK);
        idle_inputs();
        #1;
        test_counters("branch_wait");
    endtask

    task automatic test_timeout;
        MEM_req = 1'b1; MEM_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ((ctl !== FREEZE) || (mem_err !== 1'b0)) begin
                errors++;
                $display("FAIL timeout_pre[%0d] got ctl=%b err=%b expected ctl=%b err=0",
                         i, ctl, mem_err, FREEZE);
            end
            exp_stall++;
            @(negedge CLK);
        end
        #1;
        checks++;
        if (mem_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err got %b expected 1", mem_err);
        end
        MEM_ready = 1'b1; EX_branch_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ((ctl !== FREEZE) || (mem_err !== 1'b1)) begin
                errors++;
                $display("FAIL timeout_hold[%0d] got ctl=%b err=%b expected ctl=%b err=1",
                         i, ctl, mem_err, FREEZE);
            end
            exp_stall++;
            @(negedge CLK);
        end
        #1;
        test_counters("timeout");
        RST = 1'b1;
        @(negedge CLK);
        #1;
        exp_stall = 0; exp_flush = 0;
        checks++;
        if (mem_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rst_err got %b expected 0", mem_err);
        end
        test_counters("timeout_rst");
        RST = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if (ctl !== RUNV) begin
            errors++;
            $display("FAIL after_timeout_rst got %b expected %b", ctl, RUNV);
        end
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch_priority();
        test_mem_wait();
        test_branch_during_wait();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
